// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: latches one aligned load/store and
// holds it on the cache port until dhit. It stalls the pipeline and tracks halt and alignment errors.
module mem_access_ctrl #(
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   valid_MEM,
  input  logic                   MemRd_MEM,
  input  logic                   MemWr_MEM,
  input  logic                   halt_MEM,
  input  logic [31:0]            Output_Port_MEM,
  input  logic [31:0]            busB_MEM,
  input  logic                   dhit,
  input  logic [31:0]            dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [31:0]            dmemaddr,
  output logic [31:0]            dmemstore,
  output logic                   mem_stall,
  output logic [31:0]            load_data,
  output logic                   load_valid,
  output logic                   halt_out,
  output logic                   err_align,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_e;

  state_e                 state_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   rd_q;
  logic [31:0]            load_data_q;
  logic                   load_valid_q;
  logic                   halt_q;
  logic                   err_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  logic live_op;
  logic aligned;
  logic conflict;
  logic req;
  logic bad;
  logic halt_req;
  logic access;

  assign live_op  = valid_MEM & (MemRd_MEM | MemWr_MEM) & ~halt_MEM;
  assign aligned  = (Output_Port_MEM[1:0] == 2'b00);
  assign conflict = MemRd_MEM & MemWr_MEM;
  assign req      = live_op & aligned & ~conflict;
  assign bad      = live_op & (~aligned | conflict);
  assign halt_req = valid_MEM & halt_MEM;

  assign stall_d  = (stall_q == '1) ? stall_q : stall_q + 1'b1;

  // Stall is raised in the accepting IDLE cycle and held in ACCESS until dhit.
  always_comb begin
    mem_stall = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE:    mem_stall = req;
        ACCESS:  mem_stall = ~dhit;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  // The cache port is driven only from latched request state, never from live inputs.
  assign access       = (state_q == ACCESS);
  assign dmemREN      = access & rd_q;
  assign dmemWEN      = access & ~rd_q;
  assign dmemaddr     = access ? addr_q : '0;
  assign dmemstore    = (access & ~rd_q) ? wdata_q : '0;

  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign halt_out     = halt_q;
  assign err_align    = err_q;
  assign stall_cycles = stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= '0;
    end else begin
      load_valid_q <= 1'b0;
      if (mem_stall) stall_q <= stall_d;
      case (state_q)
        IDLE: begin
          if (halt_req) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end else if (req) begin
            state_q <= ACCESS;
            addr_q  <= Output_Port_MEM;
            wdata_q <= busB_MEM;
            rd_q    <= MemRd_MEM;
          end else if (bad) begin
            err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (dhit) begin
            state_q <= IDLE;
            if (rd_q) begin
              load_data_q  <= dmemload;
              load_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a transaction-level model predicts each cycle's
// outputs and completed load data; a negedge monitor pops and compares.
module tb_mem_access_ctrl;

  localparam int unsigned W   = 4;
  localparam int unsigned SAT = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          valid_MEM = 1'b0;
  logic          MemRd_MEM = 1'b0;
  logic          MemWr_MEM = 1'b0;
  logic          halt_MEM = 1'b0;
  logic [31:0]   Output_Port_MEM = '0;
  logic [31:0]   busB_MEM = '0;
  logic          dhit = 1'b0;
  logic [31:0]   dmemload = '0;
  logic          dmemREN;
  logic          dmemWEN;
  logic [31:0]   dmemaddr;
  logic [31:0]   dmemstore;
  logic          mem_stall;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          halt_out;
  logic          err_align;
  logic [W-1:0]  stall_cycles;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.STALL_CNT_W(W)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .valid_MEM       (valid_MEM),
    .MemRd_MEM       (MemRd_MEM),
    .MemWr_MEM       (MemWr_MEM),
    .halt_MEM        (halt_MEM),
    .Output_Port_MEM (Output_Port_MEM),
    .busB_MEM        (busB_MEM),
    .dhit            (dhit),
    .dmemload        (dmemload),
    .dmemREN         (dmemREN),
    .dmemWEN         (dmemWEN),
    .dmemaddr        (dmemaddr),
    .dmemstore       (dmemstore),
    .mem_stall       (mem_stall),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .halt_out        (halt_out),
    .err_align       (err_align),
    .stall_cycles    (stall_cycles)
  );

  typedef struct {
    logic        stall, ren, wen, hlt, err, lv, chk_store;
    logic [31:0] addr, store, ld;
    int unsigned cnt;
  } exp_t;

  exp_t        cq[$];
  logic [31:0] lq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          running = 1'b0;

  // Reference model: one outstanding transaction plus sticky flags.
  bit          m_busy, m_halted, m_err, m_lv, p_load;
  logic [31:0] p_addr, p_data, m_ld;
  int unsigned m_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_halted = 0; m_err = 0; m_lv = 0; p_load = 0;
    p_addr = '0; p_data = '0; m_ld = '0; m_total = 0;
  endtask

  // Called at posedge+1: drive one cycle, predict its outputs, advance the model at the edge.
  task automatic cyc(input logic rst, input logic v, input logic rd, input logic wr,
                     input logic hl, input logic [31:0] a, input logic [31:0] d,
                     input logic dh, input logic [31:0] dl);
    exp_t e;
    bit   live, req_ok;
    RST = rst; valid_MEM = v; MemRd_MEM = rd; MemWr_MEM = wr; halt_MEM = hl;
    Output_Port_MEM = a; busB_MEM = d; dhit = dh; dmemload = dl;
    live   = v && (rd || wr) && !hl;
    req_ok = live && (a[1:0] == 2'b00) && !(rd && wr);
    e.stall     = rst ? 1'b0 : m_halted ? 1'b0 : m_busy ? !dh : req_ok;
    e.ren       = m_busy && p_load;
    e.wen       = m_busy && !p_load;
    e.addr      = m_busy ? p_addr : 32'h0;
    e.chk_store = !(m_busy && p_load);
    e.store     = (m_busy && !p_load) ? p_data : 32'h0;
    e.hlt       = m_halted;
    e.err       = m_err;
    e.lv        = m_lv;
    e.ld        = m_ld;
    e.cnt       = m_total;
    cq.push_back(e);
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      if (e.stall && m_total < SAT) m_total++;
      m_lv = 0;
      if (m_halted) begin
      end else if (m_busy) begin
        if (dh) begin
          m_busy = 0;
          if (p_load) begin
            m_ld = dl; m_lv = 1; lq.push_back(dl);
          end
        end
      end else if (v && hl) begin
        m_halted = 1;
      end else if (req_ok) begin
        m_busy = 1; p_load = rd; p_addr = a; p_data = d;
      end else if (live) begin
        m_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  exp_t e_mon;
  initial begin
    forever begin
      @(negedge CLK);
      if (cq.size() > 0) begin
        e_mon = cq.pop_front();
        chk("mem_stall",    32'(mem_stall),    32'(e_mon.stall));
        chk("dmemREN",      32'(dmemREN),      32'(e_mon.ren));
        chk("dmemWEN",      32'(dmemWEN),      32'(e_mon.wen));
        chk("dmemaddr",     dmemaddr,          e_mon.addr);
        if (e_mon.chk_store) chk("dmemstore", dmemstore, e_mon.store);
        chk("halt_out",     32'(halt_out),     32'(e_mon.hlt));
        chk("err_align",    32'(err_align),    32'(e_mon.err));
        chk("load_valid",   32'(load_valid),   32'(e_mon.lv));
        chk("load_data",    load_data,         e_mon.ld);
        chk("stall_cycles", 32'(stall_cycles), e_mon.cnt);
      end else if (running) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: no expected entry for cycle at %0t", $time);
      end
      if (load_valid === 1'b1) begin
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_pulse: got load_valid=1 expected no completed load at %0t", $time);
        end else begin
          chk("load_pulse_data", load_data, lq.pop_front());
        end
      end
    end
  end

  logic        r_rst, r_v, r_rd, r_wr, r_hl, r_dh;
  logic [31:0] r_a, r_d, r_dl;
  int unsigned op;

  initial begin
    model_reset();
    running = 1'b1;
    @(posedge CLK); #1;
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0);

    // Load 0x40, three wait cycles with changing inputs, then dhit
    cyc(0, 1, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0);
    repeat (3) cyc(0, 1, 0, 1, 0, 32'h80, 32'h5, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF);
    idle();
    // Store with dhit on first access cycle
    cyc(0, 1, 0, 1, 0, 32'h100, 32'h12345678, 0, 32'h0);
    cyc(0, 1, 0, 1, 0, 32'h100, 32'h12345678, 1, 32'hFFFF0000);
    idle(); idle();
    // Misaligned load, then rd+wr conflict
    cyc(0, 1, 1, 0, 0, 32'h42, 32'h0, 1, 32'h0);
    idle(); idle();
    cyc(0, 1, 1, 1, 0, 32'h200, 32'h0, 0, 32'h0);
    idle();
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    // Reset on the second access cycle, dhit in the reset cycle ignored
    cyc(0, 1, 1, 0, 0, 32'h300, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hBAD0BAD0);
    idle();
    cyc(0, 1, 1, 0, 0, 32'h304, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0BADF00D);
    idle();
    // Three back-to-back loads, new request in the cycle after each completion
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 32'h400 + 32'(4 * k), 32'h0, 0, 32'h0);
      cyc(0, 1, 1, 0, 0, 32'h400 + 32'(4 * k), 32'h0, 1, 32'hA000 + 32'(k));
    end
    idle();
    // Long stall drives the counter into saturation
    cyc(0, 1, 1, 0, 0, 32'h500, 32'h0, 0, 32'h0);
    repeat (20) cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h55AA55AA);
    idle();
    // Halt beats a simultaneous store; later load ignored
    cyc(0, 1, 0, 1, 1, 32'h600, 32'h77, 0, 32'h0);
    cyc(0, 1, 1, 0, 0, 32'h604, 32'h0, 1, 32'h1111);
    cyc(0, 1, 0, 1, 0, 32'h43, 32'h0, 1, 32'h2222);
    idle();
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) < 3);
      r_v   = ($urandom_range(0, 99) < 80);
      op    = $urandom_range(0, 99);
      r_rd  = (op < 45) || (op >= 85 && op < 92);
      r_wr  = (op >= 45 && op < 92);
      r_hl  = ($urandom_range(0, 99) < 2);
      r_a   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 10) r_a[1:0] = 2'($urandom_range(1, 3));
      r_d   = $urandom;
      r_dh  = ($urandom_range(0, 99) < 40);
      r_dl  = $urandom;
      cyc(r_rst, r_v, r_rd, r_wr, r_hl, r_a, r_d, r_dh, r_dl);
    end

    running = 1'b0;
    @(negedge CLK);
    #1;
    chk("load_queue_drained", 32'(lq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
